// File: rtl/param_shadow_bank.sv
// Double-buffered scene/camera parameter bank: the bridge writes staging, and the active copy updates atomically at frame start.
// Optional feature: define PARAM_BANK_TIMEOUT_EN to force a commit when frame_start stalls for TIMEOUT_CYC cycles.
module param_shadow_bank #(
    parameter int NUM_CH      = 17,
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 5,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     commit_req,
    input  logic                     frame_start,
    input  logic                     rd_en,
    input  logic [ADDR_W-1:0]        rd_addr,
    input  logic                     rd_sel,
    input  logic                     err_clr,
    output logic [NUM_CH*DATA_W-1:0] active_flat,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_valid,
    output logic                     commit_pending,
    output logic                     commit_done,
    output logic                     addr_err,
`ifdef PARAM_BANK_TIMEOUT_EN
    output logic                     timeout_hit,
`endif
    output logic [15:0]              frame_count
);

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    localparam logic [ADDR_W:0] NUM_CH_L = (ADDR_W+1)'(NUM_CH);

    state_t              state_r;
    state_t              state_nx_s;
    logic                commit_s;
    logic                timeout_s;
    logic                wr_ok_s;
    logic                rd_ok_s;
    logic                err_new_s;
    logic [DATA_W-1:0]   rd_word_s;
    logic [DATA_W-1:0]   staging_r [NUM_CH];
    logic [DATA_W-1:0]   active_r  [NUM_CH];

    assign wr_ok_s   = wr_en && ({1'b0, wr_addr} < NUM_CH_L);
    assign rd_ok_s   = rd_en && ({1'b0, rd_addr} < NUM_CH_L);
    assign err_new_s = (wr_en && !wr_ok_s) || (rd_en && !rd_ok_s);

`ifdef PARAM_BANK_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYC - 1);

    logic [TO_W-1:0] to_cnt_r;

    // Wait counter: held at zero outside PENDING so it restarts on every arm.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            to_cnt_r <= {TO_W{1'b0}};
        end else if (state_r == IDLE) begin
            to_cnt_r <= {TO_W{1'b0}};
        end else if (to_cnt_r != TO_MAX) begin
            to_cnt_r <= to_cnt_r + TO_W'(1);
        end else begin
            to_cnt_r <= to_cnt_r;
        end
    end

    assign timeout_s = (state_r == PENDING) && (to_cnt_r == TO_MAX);

    // Flags only commits that were forced, not ones coinciding with a real frame_start.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            timeout_hit <= 1'b0;
        end else begin
            timeout_hit <= timeout_s && !frame_start;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Commit FSM next state; a same-cycle commit_req in IDLE only arms, in PENDING it is absorbed.
    always_comb begin
        state_nx_s = state_r;
        commit_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (commit_req) begin
                    state_nx_s = PENDING;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            PENDING: begin
                if (frame_start || timeout_s) begin
                    state_nx_s = IDLE;
                    commit_s   = 1'b1;
                end else begin
                    state_nx_s = PENDING;
                end
            end
            default: begin
                state_nx_s = IDLE;
                commit_s   = 1'b0;
            end
        endcase
    end

    // FSM state register and its registered status outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r        <= IDLE;
            commit_pending <= 1'b0;
            commit_done    <= 1'b0;
        end else begin
            state_r        <= state_nx_s;
            commit_pending <= (state_nx_s == PENDING);
            commit_done    <= commit_s;
        end
    end

    // Staging copy written by the bridge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                staging_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_ok_s && (wr_addr == ADDR_W'(i))) begin
                    staging_r[i] <= wr_data;
                end else begin
                    staging_r[i] <= staging_r[i];
                end
            end
        end
    end

    // Active copy; the non-blocking copy takes staging as it was before any same-edge write.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                active_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (commit_s) begin
                    active_r[i] <= staging_r[i];
                end else begin
                    active_r[i] <= active_r[i];
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_flat
        assign active_flat[g*DATA_W +: DATA_W] = active_r[g];
    end

    // Readback source mux; out-of-range addresses read as zero.
    always_comb begin
        rd_word_s = {DATA_W{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_ok_s && (rd_addr == ADDR_W'(i))) begin
                if (rd_sel) begin
                    rd_word_s = active_r[i];
                end else begin
                    rd_word_s = staging_r[i];
                end
            end else begin
                rd_word_s = rd_word_s;
            end
        end
    end

    // Registered readback with a single-cycle valid.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_data  <= {DATA_W{1'b0}};
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= rd_word_s;
            end else begin
                rd_data <= rd_data;
            end
        end
    end

    // Sticky address error; a new error beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            addr_err <= 1'b0;
        end else if (err_new_s) begin
            addr_err <= 1'b1;
        end else if (err_clr) begin
            addr_err <= 1'b0;
        end else begin
            addr_err <= addr_err;
        end
    end

    // Free-running frame counter, wraps naturally.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            frame_count <= 16'd0;
        end else if (frame_start) begin
            frame_count <= frame_count + 16'd1;
        end else begin
            frame_count <= frame_count;
        end
    end

endmodule

// File: tb/tb_param_shadow_bank.sv
// Table-driven bench for param_shadow_bank with a readback scoreboard.
module tb_param_shadow_bank;

    localparam int NUM_CH = 17;
    localparam int DW     = 32;
    localparam int FW     = NUM_CH * DW;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            wr_en = 1'b0;
    logic [4:0]      wr_addr = 5'd0;
    logic [31:0]     wr_data = 32'd0;
    logic            commit_req = 1'b0;
    logic            frame_start = 1'b0;
    logic            rd_en = 1'b0;
    logic [4:0]      rd_addr = 5'd0;
    logic            rd_sel = 1'b0;
    logic            err_clr = 1'b0;
    logic [FW-1:0]   active_flat;
    logic [31:0]     rd_data;
    logic            rd_valid;
    logic            commit_pending;
    logic            commit_done;
    logic            addr_err;
    logic [15:0]     frame_count;
`ifdef PARAM_BANK_TIMEOUT_EN
    logic            timeout_hit;
`endif

    param_shadow_bank #(
        .NUM_CH(NUM_CH), .DATA_W(DW), .ADDR_W(5), .TIMEOUT_CYC(8)
    ) dut (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .commit_req(commit_req), .frame_start(frame_start),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_sel(rd_sel), .err_clr(err_clr),
        .active_flat(active_flat), .rd_data(rd_data), .rd_valid(rd_valid),
        .commit_pending(commit_pending), .commit_done(commit_done),
        .addr_err(addr_err),
`ifdef PARAM_BANK_TIMEOUT_EN
        .timeout_hit(timeout_hit),
`endif
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr_en;
        logic [4:0]  wr_addr;
        logic [31:0] wr_data;
        logic        commit_req;
        logic        frame_start;
        logic        rd_en;
        logic [4:0]  rd_addr;
        logic        rd_sel;
        logic        err_clr;
        logic [31:0] exp_rd;
        logic        exp_pend;
        logic        exp_done;
        logic        exp_err;
        logic [15:0] exp_fc;
        logic [4:0]  act_ch;
        logic [31:0] exp_act;
    } vec_t;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q [$];
    vec_t        tbl [32];

    task automatic chk(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard: every read pushed at drive time must come back with rd_valid one edge later.
    always @(posedge clk) begin
        #1;
        if (reset_n && (rd_valid || exp_q.size() > 0)) begin
            n_checks++;
            if (!rd_valid) begin
                n_errors++;
                $display("FAIL rd_valid: got 0 expected 1");
                void'(exp_q.pop_front());
            end else if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL rd_valid_spurious: got 1 expected 0");
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (rd_data !== e) begin
                    n_errors++;
                    $display("FAIL rd_data: got %0h expected %0h", rd_data, e);
                end
            end
        end
    end

    task automatic drive(input vec_t v);
        @(negedge clk);
        wr_en = v.wr_en; wr_addr = v.wr_addr; wr_data = v.wr_data;
        commit_req = v.commit_req; frame_start = v.frame_start;
        rd_en = v.rd_en; rd_addr = v.rd_addr; rd_sel = v.rd_sel; err_clr = v.err_clr;
        if (v.rd_en) exp_q.push_back(v.exp_rd);
        @(posedge clk);
        #1;
    endtask

    task automatic step(input vec_t v, input int idx);
        drive(v);
        chk($sformatf("pend[%0d]", idx), FW'(commit_pending), FW'(v.exp_pend));
        chk($sformatf("done[%0d]", idx), FW'(commit_done), FW'(v.exp_done));
        chk($sformatf("err[%0d]", idx), FW'(addr_err), FW'(v.exp_err));
        chk($sformatf("fc[%0d]", idx), FW'(frame_count), FW'(v.exp_fc));
        chk($sformatf("act[%0d]", idx), FW'(active_flat[int'(v.act_ch)*DW +: DW]), FW'(v.exp_act));
    endtask

    function automatic vec_t idle();
        vec_t v;
        v = '{1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0,
              32'h0, 1'b0, 1'b0, 1'b0, 16'd0, 5'd0, 32'h0};
        return v;
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_active"}, active_flat, {FW{1'b0}});
        chk({tag, "_rd_data"}, FW'(rd_data), {FW{1'b0}});
        chk({tag, "_rd_valid"}, FW'(rd_valid), {FW{1'b0}});
        chk({tag, "_pend"}, FW'(commit_pending), {FW{1'b0}});
        chk({tag, "_done"}, FW'(commit_done), {FW{1'b0}});
        chk({tag, "_err"}, FW'(addr_err), {FW{1'b0}});
        chk({tag, "_fc"}, FW'(frame_count), {FW{1'b0}});
    endtask

    initial begin
        vec_t          v;
        logic [FW-1:0] exp_flat;
        logic [31:0]   stg [NUM_CH];

        //           wr   wa     wd            cr    fs    rd    ra     rs    ec     exp_rd       pend  done  err   fc      ch     act
        tbl[0]  = '{1'b0,5'd0, 32'h0,        1'b0,1'b0, 1'b1,5'd3, 1'b0,1'b0, 32'h103,     1'b0,1'b0,1'b0,16'd0, 5'd9, 32'h0};
        tbl[1]  = '{1'b0,5'd0, 32'h0,        1'b1,1'b0, 1'b0,5'd0, 1'b0,1'b0, 32'h0,       1'b1,1'b0,1'b0,16'd0, 5'd9, 32'h0};
        tbl[2]  = '{1'b0,5'd0, 32'h0,        1'b0,1'b0, 1'b0,5'd0, 1'b0,1'b0, 32'h0,       1'b1,1'b0,1'b0,16'd0, 5'd9, 32'h0};
        tbl[3]  = '{1'b0,5'd0, 32'h0,        1'b0,1'b0, 1'b0,5'd0, 1'b0,1'b0, 32'h0,       1'b1,1'b0,1'b0,16'd0, 5'd9, 32'h0};
        tbl[4]  = '{1'b0,5'd0, 32'h0,        1'b0,1'b0, 1'b0,5'd0, 1'b0,1'b0, 32'h0,       1'b1,1'b0,1'b0,16'd0, 5'd9, 32'h0};
        tbl[5]  = '{1'b0,5'd0, 32'h0,        1'b0,1'b0, 1'b0,5'd0, 1'b0,1'b0, 32'h0,       1'b1,1'b0,1'b0,16'd0, 5'd9, 32'h0};
        tbl[6]  = '{1'b0,5'd0, 32'h0,        1'b0,1'b0, 1'b1,5'd9, 1'b1,1'b0, 32'h0,       1'b1,1'b0,1'b0,16'd0, 5'd9, 32'h0};
        tbl[7]  = '{1'b0,5'd0, 32'h0,        1'b0,1'b1, 1'b0,5'd0, 1'b0,1'b0, 32'h0,       1'b0,1'b1,1'b0,16'd1, 5'd9, 32'h109};
        tbl[8]  = '{1'b0,5'd0, 32'h0,        1'b0,1'b0, 1'b1,5'd9, 1'b1,1'b0, 32'h109,     1'b0,1'b0,1'b0,16'd1, 5'd9, 32'h109};
        tbl[9]  = '{1'b0,5'd0, 32'h0,        1'b0,1'b0, 1'b0,5'd0, 1'b0,1'b0, 32'h0,       1'b0,1'b0,1'b0,16'd1, 5'd9, 32'h109};
        tbl[10] = '{1'b1,5'd9, 32'h209,      1'b0,1'b0, 1'b0,5'd0, 1'b0,1'b0, 32'h0,       1'b0,1'b0,1'b0,16'd1, 5'd9, 32'h109};
        tbl[11] = '{1'b0,5'd0, 32'h0,        1'b1,1'b1, 1'b0,5'd0, 1'b0,1'b0, 32'h0,       1'b1,1'b0,1'b0,16'd2, 5'd9, 32'h109};
        tbl[12] = '{1'b0,5'd0, 32'h0,        1'b0,1'b0, 1'b0,5'd0, 1'b0,1'b0, 32'h0,       1'b1,1'b0,1'b0,16'd2, 5'd9, 32'h109};
        tbl[13] = '{1'b0,5'd0, 32'h0,        1'b0,1'b1, 1'b0,5'd0, 1'b0,1'b0, 32'h0,       1'b0,1'b1,1'b0,16'd3, 5'd9, 32'h209};
        tbl[14] = '{1'b0,5'd0, 32'h0,        1'b1,1'b0, 1'b0,5'd0, 1'b0,1'b0, 32'h0,       1'b1,1'b0,1'b0,16'd3, 5'd9, 32'h209};
        tbl[15] = '{1'b0,5'd0, 32'h0,        1'b1,1'b0, 1'b0,5'd0, 1'b0,1'b0, 32'h0,       1'b1,1'b0,1'b0,16'd3, 5'd9, 32'h209};
        tbl[16] = '{1'b1,5'd2, 32'hDEAD,     1'b1,1'b1, 1'b0,5'd0, 1'b0,1'b0, 32'h0,       1'b0,1'b1,1'b0,16'd4, 5'd2, 32'h102};
        tbl[17] = '{1'b0,5'd0, 32'h0,        1'b0,1'b0, 1'b1,5'd2, 1'b0,1'b0, 32'hDEAD,    1'b0,1'b0,1'b0,16'd4, 5'd2, 32'h102};
        tbl[18] = '{1'b0,5'd0, 32'h0,        1'b0,1'b0, 1'b1,5'd2, 1'b1,1'b0, 32'h102,     1'b0,1'b0,1'b0,16'd4, 5'd2, 32'h102};
        tbl[19] = '{1'b0,5'd0, 32'h0,        1'b0,1'b1, 1'b0,5'd0, 1'b0,1'b0, 32'h0,       1'b0,1'b0,1'b0,16'd5, 5'd2, 32'h102};
        tbl[20] = '{1'b0,5'd0, 32'h0,        1'b1,1'b0, 1'b0,5'd0, 1'b0,1'b0, 32'h0,       1'b1,1'b0,1'b0,16'd5, 5'd2, 32'h102};
        tbl[21] = '{1'b0,5'd0, 32'h0,        1'b0,1'b1, 1'b0,5'd0, 1'b0,1'b0, 32'h0,       1'b0,1'b1,1'b0,16'd6, 5'd2, 32'hDEAD};
        tbl[22] = '{1'b1,5'd20,32'hBAD,      1'b0,1'b0, 1'b1,5'd31,1'b0,1'b0, 32'h0,       1'b0,1'b0,1'b1,16'd6, 5'd2, 32'hDEAD};
        tbl[23] = '{1'b0,5'd0, 32'h0,        1'b0,1'b0, 1'b0,5'd0, 1'b0,1'b0, 32'h0,       1'b0,1'b0,1'b1,16'd6, 5'd2, 32'hDEAD};
        tbl[24] = '{1'b0,5'd0, 32'h0,        1'b0,1'b0, 1'b0,5'd0, 1'b0,1'b1, 32'h0,       1'b0,1'b0,1'b0,16'd6, 5'd2, 32'hDEAD};
        tbl[25] = '{1'b1,5'd17,32'h1234,     1'b0,1'b0, 1'b0,5'd0, 1'b0,1'b1, 32'h0,       1'b0,1'b0,1'b1,16'd6, 5'd2, 32'hDEAD};
        tbl[26] = '{1'b0,5'd0, 32'h0,        1'b0,1'b0, 1'b0,5'd0, 1'b0,1'b1, 32'h0,       1'b0,1'b0,1'b0,16'd6, 5'd2, 32'hDEAD};
        tbl[27] = '{1'b0,5'd0, 32'h0,        1'b0,1'b0, 1'b1,5'd17,1'b1,1'b0, 32'h0,       1'b0,1'b0,1'b1,16'd6, 5'd2, 32'hDEAD};
        tbl[28] = '{1'b0,5'd0, 32'h0,        1'b0,1'b0, 1'b0,5'd0, 1'b0,1'b1, 32'h0,       1'b0,1'b0,1'b0,16'd6, 5'd2, 32'hDEAD};
        tbl[29] = '{1'b0,5'd0, 32'h0,        1'b0,1'b0, 1'b1,5'd16,1'b0,1'b0, 32'h110,     1'b0,1'b0,1'b0,16'd6, 5'd16,32'h110};
        tbl[30] = '{1'b1,5'd5, 32'h555,      1'b0,1'b0, 1'b1,5'd5, 1'b0,1'b0, 32'h105,     1'b0,1'b0,1'b0,16'd6, 5'd5, 32'h105};
        tbl[31] = '{1'b0,5'd0, 32'h0,        1'b0,1'b0, 1'b1,5'd5, 1'b0,1'b0, 32'h555,     1'b0,1'b0,1'b0,16'd6, 5'd5, 32'h105};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Fill staging, confirm active untouched
        for (int i = 0; i < NUM_CH; i++) begin
            v = idle();
            v.wr_en = 1'b1; v.wr_addr = 5'(i); v.wr_data = 32'h100 + 32'(i);
            drive(v);
        end
        for (int i = 0; i < NUM_CH; i++) begin
            v = idle();
            v.rd_en = 1'b1; v.rd_addr = 5'(i); v.rd_sel = 1'b1; v.exp_rd = 32'h0;
            drive(v);
        end
        chk("active_after_fill", active_flat, {FW{1'b0}});

        for (int i = 0; i < 32; i++) begin
            step(tbl[i], i);
        end

        // Final model of staging and active
        for (int i = 0; i < NUM_CH; i++) stg[i] = 32'h100 + 32'(i);
        stg[9] = 32'h209;
        stg[2] = 32'hDEAD;
        for (int i = 0; i < NUM_CH; i++) exp_flat[i*DW +: DW] = stg[i];
        chk("active_final", active_flat, exp_flat);
        stg[5] = 32'h555;
        for (int i = 0; i < NUM_CH; i++) begin
            v = idle();
            v.rd_en = 1'b1; v.rd_addr = 5'(i); v.exp_rd = stg[i];
            drive(v);
        end

`ifdef PARAM_BANK_TIMEOUT_EN
        // Forced commit after TIMEOUT_CYC cycles with no frame_start
        v = idle(); v.wr_en = 1'b1; v.wr_addr = 5'd0; v.wr_data = 32'hABC;
        drive(v);
        v = idle(); v.commit_req = 1'b1;
        drive(v);
        chk("to_arm_pend", FW'(commit_pending), FW'(1'b1));
        for (int k = 1; k <= 8; k++) begin
            drive(idle());
            chk($sformatf("to_done_%0d", k), FW'(commit_done), FW'(k == 8));
            chk($sformatf("to_hit_%0d", k), FW'(timeout_hit), FW'(k == 8));
            chk($sformatf("to_pend_%0d", k), FW'(commit_pending), FW'(k != 8));
        end
        chk("to_active_ch0", FW'(active_flat[0 +: DW]), FW'(32'hABC));
        drive(idle());
        chk("to_hit_after", FW'(timeout_hit), FW'(1'b0));
        chk("to_done_after", FW'(commit_done), FW'(1'b0));
`endif

        // Reset while a commit is armed discards it
        v = idle(); v.commit_req = 1'b1;
        drive(v);
        chk("rst_arm_pend", FW'(commit_pending), FW'(1'b1));
        v = idle(); v.wr_en = 1'b1; v.wr_addr = 5'd1; v.wr_data = 32'h777;
        drive(v);
        drive(idle());
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("midreset");
`ifdef PARAM_BANK_TIMEOUT_EN
        chk("midreset_hit", FW'(timeout_hit), FW'(1'b0));
`endif
        @(negedge clk);
        reset_n = 1'b1;
        v = idle(); v.frame_start = 1'b1;
        drive(v);
        chk("post_rst_done", FW'(commit_done), FW'(1'b0));
        chk("post_rst_active", active_flat, {FW{1'b0}});
        chk("post_rst_fc", FW'(frame_count), FW'(16'd1));
        drive(idle());
        chk("post_rst_done2", FW'(commit_done), FW'(1'b0));

        repeat (2) @(posedge clk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/param_shadow_bank.md
Name: param_shadow_bank

Overview:
- Parametrised, double-buffered bank of scene/camera parameter registers.
- Generalises the fixed set of per-export 32-bit PIOs (eye position, 3x3 look-at matrix, colour shifts, fog, repetition, colour enables) into NUM_CH channels of DATA_W bits.
- The HPS-side bridge writes a staging copy. The raymarch pipeline sees an active copy, which updates atomically only at a frame boundary, so no frame renders with a half-updated camera.

Parameters:
- NUM_CH, 17: number of parameter channels.
- DATA_W, 32: channel width in bits.
- ADDR_W, 5: channel address width; must satisfy 2^ADDR_W >= NUM_CH.
- TIMEOUT_CYC, 1000000: clock cycles a pending commit waits for frame_start before a forced commit (used only with the optional feature).

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- wr_en  in  1  staging write strobe.
- wr_addr  in  ADDR_W  staging channel index.
- wr_data  in  DATA_W  staging write data.
- commit_req  in  1  one-cycle request to publish staging to active.
- frame_start  in  1  one-cycle pulse from the VGA/raster side at frame start.
- rd_en  in  1  readback strobe.
- rd_addr  in  ADDR_W  readback channel index.
- rd_sel  in  1  readback source: 0 = staging, 1 = active.
- err_clr  in  1  clears addr_err.
- active_flat  out  NUM_CH*DATA_W  active copy; channel i at [i*DATA_W +: DATA_W].
- rd_data  out  DATA_W  readback data.
- rd_valid  out  1  readback data valid.
- commit_pending  out  1  a commit is armed.
- commit_done  out  1  one-cycle pulse when active is updated.
- addr_err  out  1  sticky out-of-range access flag.
- frame_count  out  16  frames seen since reset; wraps.

Behaviour:
- Reset (reset_n low at a clk edge):
  - All staging and active channels, rd_data, frame_count = 0.
  - rd_valid, commit_pending, commit_done, addr_err = 0.
  - FSM = IDLE. Reset mid-commit discards the armed commit.
- Staging write: when wr_en and wr_addr < NUM_CH, staging[wr_addr] <= wr_data at the next edge.
  - wr_addr >= NUM_CH: write dropped, addr_err set.
- Readback: rd_en at cycle N gives rd_data and a one-cycle rd_valid at N+1.
  - Source is staging or active per rd_sel.
  - Out-of-range rd_addr returns 0 and sets addr_err.
  - A write and a read of the same staging channel in the same cycle returns the old value.
- addr_err: sticky; cleared by err_clr. If a new error and err_clr arrive in the same cycle, the error wins and addr_err stays 1.
- FSM states: IDLE, PENDING.
  - IDLE -> PENDING on commit_req.
  - PENDING -> IDLE when frame_start is high. On that edge, active <= staging for all channels in a single cycle. commit_done pulses high on the following cycle.
  - commit_req while in PENDING is absorbed; only one commit occurs.
  - commit_req and frame_start in the same cycle while IDLE: arm only. The commit happens at the next frame_start.
  - commit_req and frame_start in the same cycle while PENDING: the commit happens and the FSM returns to IDLE. The new commit_req is not re-armed.
- Commit-cycle write: a staging write in the same cycle as the commit edge lands in staging only. Active receives the pre-write value.
- commit_pending = (state == PENDING).
- frame_count increments on every frame_start and wraps 0xFFFF -> 0.
- active_flat is a direct register output with no combinational path from inputs.

Optional Feature:
- Macro: PARAM_BANK_TIMEOUT_EN.
- Defined:
  - A counter runs while in PENDING; it is cleared on entry to PENDING.
  - When it reaches TIMEOUT_CYC-1 without a frame_start, the commit happens as on frame_start (forced commit), and commit_done pulses.
  - An extra output port timeout_hit (1 bit) pulses together with that commit_done.
  - Covers a stalled or disconnected VGA clock domain.
- Undefined: no counter and no timeout_hit port; PENDING waits indefinitely for frame_start.

Test Plan:
- Reset, then write staging[0..16] = 0x100+i with no commit; read with rd_sel=1 -> all 0 and active_flat == 0. Read with rd_sel=0 -> ch3 = 0x103, rd_valid one cycle after rd_en.
- commit_req, wait 5 cycles, frame_start -> commit_pending 1 during the wait. Active ch9 = 0x109 on the edge after frame_start, commit_done single pulse next cycle, frame_count = 1.
- commit_req and frame_start in the same cycle while IDLE -> no update. The next frame_start commits and commit_done pulses once.
- While PENDING, write ch2 = 0xDEAD in the same cycle as frame_start -> active ch2 holds the prior staging value. Staging ch2 = 0xDEAD, visible after the next commit.
- Write to wr_addr = 20 and read rd_addr = 31 -> no channel changes, rd_data = 0, addr_err = 1. err_clr -> addr_err = 0.
- With PARAM_BANK_TIMEOUT_EN and TIMEOUT_CYC = 8: commit_req, then no frame_start -> commit and timeout_hit pulse 8 cycles after arming. Drop reset_n while PENDING -> the commit is discarded and all outputs return to 0.
